// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_if
// Purpose  : Decode-side, forwarding-source and EX-side signals of the ID/EX
//            pipeline register bundled with master/slave views.
// Revision : 1.0 - initial release
// ============================================================================
interface id_ex_stage_if #(
  parameter int XLEN = 32,
  parameter int RW   = 5
);
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [RW-1:0]   id_rs1;
  logic [RW-1:0]   id_rs2;
  logic [RW-1:0]   id_rd;
  logic [3:0]      id_aluop;
  logic            id_alusrc;
  logic [3:0]      id_ctrl;
  logic            flush;
  logic            hold;
  logic            mem_regwrite;
  logic            wb_regwrite;
  logic [RW-1:0]   mem_rd;
  logic [RW-1:0]   wb_rd;
  logic [XLEN-1:0] mem_result;
  logic [XLEN-1:0] wb_result;
  logic            load_use_stall;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_a;
  logic [XLEN-1:0] ex_b;
  logic [XLEN-1:0] ex_store_data;
  logic [3:0]      ex_aluop;
  logic [RW-1:0]   ex_rd;
  logic [3:0]      ex_ctrl;

  // Master: decode/hazard side that feeds the stage.
  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_aluop, id_alusrc, id_ctrl,
           flush, hold, mem_regwrite, wb_regwrite, mem_rd, wb_rd,
           mem_result, wb_result,
    input  load_use_stall, ex_valid, ex_pc, ex_a, ex_b, ex_store_data,
           ex_aluop, ex_rd, ex_ctrl
  );

  // Slave: the pipeline register itself.
  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_aluop, id_alusrc, id_ctrl,
           flush, hold, mem_regwrite, wb_regwrite, mem_rd, wb_rd,
           mem_result, wb_result,
    output load_use_stall, ex_valid, ex_pc, ex_a, ex_b, ex_store_data,
           ex_aluop, ex_rd, ex_ctrl
  );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : RV32 ID/EX register with MEM/WB forwarding, load-use bubbling,
//            hold and branch flush, feeding the ALU operands directly.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int RW   = 5
) (
  input  wire logic        clk,
  input  wire logic        rst,
  id_ex_stage_if.slave     bus
);

  localparam int c_MEMREAD_BIT = 2;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [RW-1:0]   rd;
    logic [3:0]      aluop;
    logic            alusrc;
    logic [3:0]      ctrl;
  } stage_t;

  stage_t          stage_q;
  stage_t          stage_d;
  logic [XLEN-1:0] w_fwd_rs1;
  logic [XLEN-1:0] w_fwd_rs2;
  logic [XLEN-1:0] w_cap_rs1;
  logic [XLEN-1:0] w_cap_rs2;
  logic            w_stall;

  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [RW-1:0]   idx,
    input logic [XLEN-1:0] stored,
    input logic            mem_we,
    input logic [RW-1:0]   mem_rd,
    input logic [XLEN-1:0] mem_val,
    input logic            wb_we,
    input logic [RW-1:0]   wb_rd,
    input logic [XLEN-1:0] wb_val
  );
    logic [XLEN-1:0] r;
    r = stored;
    if (idx != '0) begin
      if (mem_we && (mem_rd == idx))
        r = mem_val;
      else if (wb_we && (wb_rd == idx))
        r = wb_val;
    end
    return r;
  endfunction

  // EX-side forwarding uses both producers; the decode-side bypass only needs
  // WB, since MEM results are caught by EX-side forwarding next cycle.
  assign w_fwd_rs1 = fwd_sel(stage_q.rs1, stage_q.rs1_data,
                             bus.mem_regwrite, bus.mem_rd, bus.mem_result,
                             bus.wb_regwrite, bus.wb_rd, bus.wb_result);
  assign w_fwd_rs2 = fwd_sel(stage_q.rs2, stage_q.rs2_data,
                             bus.mem_regwrite, bus.mem_rd, bus.mem_result,
                             bus.wb_regwrite, bus.wb_rd, bus.wb_result);
  assign w_cap_rs1 = fwd_sel(bus.id_rs1, bus.id_rs1_data,
                             1'b0, '0, '0,
                             bus.wb_regwrite, bus.wb_rd, bus.wb_result);
  assign w_cap_rs2 = fwd_sel(bus.id_rs2, bus.id_rs2_data,
                             1'b0, '0, '0,
                             bus.wb_regwrite, bus.wb_rd, bus.wb_result);

  assign w_stall = bus.id_valid && stage_q.valid && stage_q.ctrl[c_MEMREAD_BIT] &&
                   (stage_q.rd != '0) &&
                   ((stage_q.rd == bus.id_rs1) || (stage_q.rd == bus.id_rs2));

  always_comb begin
    stage_d = stage_q;
    if (bus.flush) begin
      stage_d = '0;
    end else if (bus.hold) begin
      // Refresh operands so a producer retiring from WB mid-hold is kept.
      stage_d.rs1_data = w_fwd_rs1;
      stage_d.rs2_data = w_fwd_rs2;
    end else if (w_stall) begin
      stage_d = '0;
    end else begin
      stage_d.valid    = bus.id_valid;
      stage_d.pc       = bus.id_pc;
      stage_d.rs1_data = w_cap_rs1;
      stage_d.rs2_data = w_cap_rs2;
      stage_d.imm      = bus.id_imm;
      stage_d.rs1      = bus.id_rs1;
      stage_d.rs2      = bus.id_rs2;
      stage_d.rd       = bus.id_rd;
      stage_d.aluop    = bus.id_aluop;
      stage_d.alusrc   = bus.id_alusrc;
      stage_d.ctrl     = bus.id_valid ? bus.id_ctrl : 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stage_q <= '0;
    else
      stage_q <= stage_d;
  end

  assign bus.load_use_stall = w_stall;
  assign bus.ex_valid       = stage_q.valid;
  assign bus.ex_pc          = stage_q.pc;
  assign bus.ex_a           = w_fwd_rs1;
  assign bus.ex_b           = stage_q.alusrc ? stage_q.imm : w_fwd_rs2;
  assign bus.ex_store_data  = w_fwd_rs2;
  assign bus.ex_aluop       = stage_q.aluop;
  assign bus.ex_rd          = stage_q.rd;
  assign bus.ex_ctrl        = stage_q.ctrl;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Directed plus randomized bench for id_ex_stage with a
//            behavioural model of the held instruction.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;
  localparam int XLEN = 32;
  localparam int RW   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  id_ex_stage_if #(.XLEN(XLEN), .RW(RW)) bus ();
  id_ex_stage #(.XLEN(XLEN), .RW(RW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Model of the instruction currently held in EX.
  typedef struct {
    bit              valid;
    logic [XLEN-1:0] pc, a, b, imm;
    int              rs1, rs2, rd;
    logic [3:0]      aluop, ctrl;
    bit              use_imm;
  } instr_t;
  instr_t m;

  function automatic instr_t nop();
    instr_t n;
    n.valid = 0; n.pc = 0; n.a = 0; n.b = 0; n.imm = 0;
    n.rs1 = 0; n.rs2 = 0; n.rd = 0; n.aluop = 0; n.ctrl = 0; n.use_imm = 0;
    return n;
  endfunction

  // Newest value of register r visible now; MEM is younger than WB.
  function automatic logic [XLEN-1:0] latest(int r, logic [XLEN-1:0] fallback, bit use_mem);
    if (r == 0) return fallback;
    if (use_mem && bus.mem_regwrite && int'(bus.mem_rd) == r) return bus.mem_result;
    if (bus.wb_regwrite && int'(bus.wb_rd) == r) return bus.wb_result;
    return fallback;
  endfunction

  function automatic bit exp_stall();
    return bus.id_valid && m.valid && m.ctrl[2] && m.rd != 0 &&
           (m.rd == int'(bus.id_rs1) || m.rd == int'(bus.id_rs2));
  endfunction

  task automatic model_edge();
    if (rst || bus.flush) m = nop();
    else if (bus.hold) begin
      m.a = latest(m.rs1, m.a, 1);
      m.b = latest(m.rs2, m.b, 1);
    end else if (exp_stall()) m = nop();
    else begin
      m.valid = bus.id_valid; m.pc = bus.id_pc;
      m.a = latest(int'(bus.id_rs1), bus.id_rs1_data, 0);
      m.b = latest(int'(bus.id_rs2), bus.id_rs2_data, 0);
      m.imm = bus.id_imm; m.rs1 = int'(bus.id_rs1); m.rs2 = int'(bus.id_rs2);
      m.rd = int'(bus.id_rd); m.aluop = bus.id_aluop; m.use_imm = bus.id_alusrc;
      m.ctrl = bus.id_valid ? bus.id_ctrl : 4'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [XLEN-1:0] ea, es;
    #1;
    ea = latest(m.rs1, m.a, 1);
    es = latest(m.rs2, m.b, 1);
    chk("load_use_stall", XLEN'(bus.load_use_stall), XLEN'(exp_stall()));
    chk("ex_valid", XLEN'(bus.ex_valid), XLEN'(m.valid));
    chk("ex_pc", bus.ex_pc, m.pc);
    chk("ex_a", bus.ex_a, ea);
    chk("ex_b", bus.ex_b, m.use_imm ? m.imm : es);
    chk("ex_store_data", bus.ex_store_data, es);
    chk("ex_aluop", XLEN'(bus.ex_aluop), XLEN'(m.aluop));
    chk("ex_rd", XLEN'(bus.ex_rd), XLEN'(m.rd));
    chk("ex_ctrl", XLEN'(bus.ex_ctrl), XLEN'(m.ctrl));
  endtask

  task automatic idle();
    bus.id_valid = 0; bus.id_pc = 0; bus.id_rs1_data = 0; bus.id_rs2_data = 0;
    bus.id_imm = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
    bus.id_aluop = 0; bus.id_alusrc = 0; bus.id_ctrl = 0;
    bus.flush = 0; bus.hold = 0;
    bus.mem_regwrite = 0; bus.wb_regwrite = 0; bus.mem_rd = 0; bus.wb_rd = 0;
    bus.mem_result = 0; bus.wb_result = 0;
  endtask

  task automatic decode(input logic [XLEN-1:0] pc, input int rs1, input int rs2, input int rd,
                        input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2, input logic [3:0] ctrl);
    bus.id_valid = 1; bus.id_pc = pc; bus.id_rs1 = RW'(rs1); bus.id_rs2 = RW'(rs2);
    bus.id_rd = RW'(rd); bus.id_rs1_data = d1; bus.id_rs2_data = d2;
    bus.id_ctrl = ctrl; bus.id_aluop = 4'b0010; bus.id_alusrc = 0; bus.id_imm = 0;
  endtask

  initial begin
    m = nop();
    idle();
    // Reset with a live decode slot.
    rst = 1; bus.id_valid = 1; bus.id_ctrl = 4'b1111; bus.id_pc = 32'h100;
    tick(); tick();
    check_all();
    chk("rst_valid", XLEN'(bus.ex_valid), 0);
    chk("rst_ctrl", XLEN'(bus.ex_ctrl), 0);
    chk("rst_a", bus.ex_a, 0);
    chk("rst_b", bus.ex_b, 0);
    rst = 0;
    tick();
    chk("first_capture_valid", XLEN'(bus.ex_valid), 1);
    chk("first_capture_pc", bus.ex_pc, 32'h100);

    // Forwarding priority on stored rs1 = x5.
    idle(); decode(32'h104, 5, 0, 9, 32'h77, 0, 4'b1000);
    tick(); idle();
    bus.mem_regwrite = 1; bus.mem_rd = 5; bus.mem_result = 32'h11;
    bus.wb_regwrite = 1; bus.wb_rd = 5; bus.wb_result = 32'h22;
    check_all(); chk("fwd_mem_first", bus.ex_a, 32'h11);
    bus.mem_regwrite = 0;
    check_all(); chk("fwd_wb", bus.ex_a, 32'h22);
    bus.mem_regwrite = 1; bus.mem_rd = 0; bus.wb_rd = 0;
    check_all(); chk("fwd_x0_none", bus.ex_a, 32'h77);

    // Immediate path with forwarded store data.
    idle(); decode(32'h108, 0, 6, 10, 0, 32'h9, 4'b0010);
    bus.id_alusrc = 1; bus.id_imm = 32'hFFFF_FFF0;
    tick(); idle();
    bus.wb_regwrite = 1; bus.wb_rd = 6; bus.wb_result = 32'h33;
    check_all();
    chk("imm_b", bus.ex_b, 32'hFFFF_FFF0);
    chk("imm_store", bus.ex_store_data, 32'h33);

    // Load-use: lw x7 then add x8,x7,x1.
    idle(); decode(32'h10C, 2, 0, 7, 0, 0, 4'b1101);
    tick(); idle(); decode(32'h110, 7, 1, 8, 0, 0, 4'b1000);
    check_all(); chk("lu_stall", XLEN'(bus.load_use_stall), 1);
    tick(); check_all();
    chk("lu_bubble_valid", XLEN'(bus.ex_valid), 0);
    chk("lu_bubble_ctrl", XLEN'(bus.ex_ctrl), 0);
    tick(); check_all();
    chk("lu_capture_valid", XLEN'(bus.ex_valid), 1);
    chk("lu_capture_rd", XLEN'(bus.ex_rd), 8);
    idle(); decode(32'h114, 2, 0, 0, 0, 0, 4'b1101);
    tick(); idle(); decode(32'h118, 0, 0, 8, 0, 0, 4'b1000);
    check_all(); chk("lu_rd0_nostall", XLEN'(bus.load_use_stall), 0);

    // Hold while the rs1 producer retires from WB.
    idle(); decode(32'h11C, 4, 0, 11, 0, 0, 4'b1000);
    tick(); idle(); bus.hold = 1;
    bus.wb_regwrite = 1; bus.wb_rd = 4; bus.wb_result = 32'h55;
    check_all(); tick();
    bus.wb_regwrite = 0;
    for (int i = 0; i < 2; i++) begin
      check_all(); chk("hold_a", bus.ex_a, 32'h55); tick();
    end
    bus.hold = 0;
    check_all(); chk("hold_release_a", bus.ex_a, 32'h55);

    // Flush wins over hold, then decode-side bypass.
    idle(); decode(32'h120, 1, 2, 3, 1, 2, 4'b1000);
    tick(); idle(); bus.flush = 1; bus.hold = 1;
    tick(); check_all(); chk("flush_over_hold", XLEN'(bus.ex_valid), 0);
    idle(); decode(32'h124, 3, 0, 12, 0, 0, 4'b1000);
    bus.wb_regwrite = 1; bus.wb_rd = 3; bus.wb_result = 32'hABCD;
    tick(); idle();
    check_all(); chk("bypass_a", bus.ex_a, 32'hABCD);

    // Randomized traffic over a small register set to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      bus.flush = ($urandom_range(0, 9) == 0);
      bus.hold = ($urandom_range(0, 5) == 0);
      bus.id_valid = ($urandom_range(0, 3) != 0);
      bus.id_pc = $urandom; bus.id_imm = $urandom;
      bus.id_rs1_data = $urandom; bus.id_rs2_data = $urandom;
      bus.id_rs1 = RW'($urandom_range(0, 7)); bus.id_rs2 = RW'($urandom_range(0, 7));
      bus.id_rd = RW'($urandom_range(0, 7));
      bus.id_aluop = 4'($urandom); bus.id_alusrc = 1'($urandom);
      bus.id_ctrl = 4'($urandom);
      bus.mem_regwrite = 1'($urandom); bus.wb_regwrite = 1'($urandom);
      bus.mem_rd = RW'($urandom_range(0, 7)); bus.wb_rd = RW'($urandom_range(0, 7));
      bus.mem_result = $urandom; bus.wb_result = $urandom;
      check_all();
      tick();
    end
    rst = 0; idle();
    check_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
